// File: rtl/game_logic_multi.sv
// N-channel enemy game logic: per-channel spawn/fly/explode/impact FSMs, click scoring and lives.
// Define GAME_LOGIC_ESCALATION_EN to shorten flight periods as killcount grows.
module game_logic_multi #(
  parameter int unsigned N_ENEMY       = 3,
  parameter int unsigned OUT_WIDTH     = 8,
  parameter int unsigned ADDRESSWIDTH  = 16,
  parameter int unsigned X_START       = 10,
  parameter int unsigned X_END         = 200,
  parameter int unsigned Y_BASE        = 40,
  parameter int unsigned Y_STEP        = 50,
  parameter int unsigned SPAWN_BASE    = 1000,
  parameter int unsigned SPAWN_STEP    = 200,
  parameter int unsigned SPEED_BASE    = 300,
  parameter int unsigned SPEED_STEP    = 100,
  parameter int unsigned DESTROY_TIME  = 1000,
  parameter int unsigned HIT_PRECISION = 10,
  parameter int unsigned LIVES         = 3,
  parameter logic [ADDRESSWIDTH-1:0] ADR_BOMBER  = ADDRESSWIDTH'(16'h0000),
  parameter logic [ADDRESSWIDTH-1:0] ADR_EXPLODE = ADDRESSWIDTH'(16'h0100)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [OUT_WIDTH-1:0]             xcursor,
  input  logic [OUT_WIDTH-1:0]             ycursor,
  input  logic                             click,
  output logic [N_ENEMY*OUT_WIDTH-1:0]     xenemy,
  output logic [N_ENEMY*OUT_WIDTH-1:0]     yenemy,
  output logic [N_ENEMY-1:0]               spawn_enemy,
  output logic [N_ENEMY*ADDRESSWIDTH-1:0]  adr_enemy,
  output logic [N_ENEMY-1:0]               base_nuked,
  output logic [OUT_WIDTH-1:0]             killcount,
  output logic [3:0]                       lives,
  output logic                             game_over
);

  localparam int unsigned SpawnMax = SPAWN_BASE + (N_ENEMY - 1) * SPAWN_STEP;
  localparam int unsigned SpeedMax = SPEED_BASE + (N_ENEMY - 1) * SPEED_STEP;
  localparam int unsigned CntMax0  = (SpawnMax > SpeedMax) ? SpawnMax : SpeedMax;
  localparam int unsigned CntMax   = (CntMax0 > DESTROY_TIME) ? CntMax0 : DESTROY_TIME;
  localparam int unsigned CntW     = $clog2(CntMax + 1);

  localparam logic [OUT_WIDTH-1:0] XStart     = OUT_WIDTH'(X_START);
  localparam logic [OUT_WIDTH-1:0] XEnd       = OUT_WIDTH'(X_END);
  localparam logic [OUT_WIDTH-1:0] HitPrec    = OUT_WIDTH'(HIT_PRECISION);
  localparam logic [OUT_WIDTH-1:0] KillMax    = '1;
  localparam logic [CntW-1:0]      DestroyLim = CntW'(DESTROY_TIME - 1);

  typedef enum logic [1:0] {StIdle, StFly, StExplode, StImpact} state_e;

  state_e                  state_q [N_ENEMY];
  state_e                  state_d [N_ENEMY];
  logic [CntW-1:0]         cnt_q   [N_ENEMY];
  logic [CntW-1:0]         cnt_d   [N_ENEMY];
  logic [OUT_WIDTH-1:0]    x_q     [N_ENEMY];
  logic [OUT_WIDTH-1:0]    x_d     [N_ENEMY];
  logic [CntW-1:0]         spd_lim [N_ENEMY];

  logic [N_ENEMY-1:0]              hit, impact, spawn_q, nuked_q, nuked_d;
  logic [N_ENEMY*ADDRESSWIDTH-1:0] adr_q;
  logic [OUT_WIDTH-1:0]            killcount_q, killcount_d;
  logic [OUT_WIDTH:0]              kill_sum;
  logic [3:0]                      lives_q, lives_d, n_hit, n_imp;
  logic                            game_over_q, game_over_d, click_q, fire_q;

  function automatic logic [OUT_WIDTH-1:0] abs_diff(logic [OUT_WIDTH-1:0] a,
                                                    logic [OUT_WIDTH-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] chan_y(int unsigned i);
    return OUT_WIDTH'(Y_BASE + i * Y_STEP);
  endfunction

  function automatic logic [CntW-1:0] spawn_lim(int unsigned i);
    return CntW'(SPAWN_BASE + i * SPAWN_STEP - 1);
  endfunction

`ifdef GAME_LOGIC_ESCALATION_EN
  localparam int unsigned LvlStep  = SPEED_BASE / 8;
  localparam int unsigned PerFloor = (LvlStep == 0) ? 1 : LvlStep;

  logic [CntW-1:0]      spd_lim_q [N_ENEMY];
  logic [CntW-1:0]      spd_next  [N_ENEMY];
  logic [OUT_WIDTH-1:0] kill_div;
  logic [2:0]           level;

  function automatic int unsigned period(int unsigned i, logic [2:0] lvl);
    int unsigned base, cut;
    base = SPEED_BASE + i * SPEED_STEP;
    cut  = 32'(lvl) * LvlStep;
    return (base >= cut + PerFloor) ? base - cut : PerFloor;
  endfunction

  assign kill_div = killcount_q >> 3;
  assign level    = (kill_div > OUT_WIDTH'(7)) ? 3'd7 : kill_div[2:0];

  always_comb begin
    for (int unsigned i = 0; i < N_ENEMY; i++) begin
      spd_next[i] = CntW'(period(i, level) - 1);
      spd_lim[i]  = spd_lim_q[i];
    end
  end

  // Any FLY cycle with a cleared speed counter is a reload point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_ENEMY; i++) begin
        spd_lim_q[i] <= CntW'(SPEED_BASE + i * SPEED_STEP - 1);
      end
    end else begin
      for (int unsigned i = 0; i < N_ENEMY; i++) begin
        if ((state_d[i] == StFly) && (cnt_d[i] == '0)) spd_lim_q[i] <= spd_next[i];
      end
    end
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < N_ENEMY; i++) begin
      spd_lim[i] = CntW'(SPEED_BASE + i * SPEED_STEP - 1);
    end
  end
`endif

  always_comb begin
    for (int unsigned i = 0; i < N_ENEMY; i++) begin
      hit[i] = fire_q && !game_over_q && (state_q[i] == StFly) &&
               (abs_diff(x_q[i], xcursor) <= HitPrec) &&
               (abs_diff(chan_y(i), ycursor) <= HitPrec);
    end
  end

  always_comb begin
    n_hit   = '0;
    n_imp   = '0;
    nuked_d = nuked_q;
    for (int unsigned i = 0; i < N_ENEMY; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      x_d[i]     = x_q[i];
      impact[i]  = 1'b0;
      if (!game_over_q) begin
        unique case (state_q[i])
          StIdle: begin
            if (cnt_q[i] == spawn_lim(i)) begin
              state_d[i] = StFly;
              cnt_d[i]   = '0;
              x_d[i]     = XStart;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          StFly: begin
            // A hit beats a same-cycle step into the base.
            if (hit[i]) begin
              state_d[i] = StExplode;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == spd_lim[i]) begin
              cnt_d[i] = '0;
              if (x_q[i] + 1'b1 == XEnd) begin
                state_d[i] = StImpact;
                x_d[i]     = XEnd;
              end else begin
                x_d[i] = x_q[i] + 1'b1;
              end
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          StExplode: begin
            if (cnt_q[i] == DestroyLim) begin
              state_d[i] = StIdle;
              cnt_d[i]   = '0;
              x_d[i]     = XStart;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          StImpact: begin
            impact[i]  = 1'b1;
            nuked_d[i] = 1'b1;
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
            x_d[i]     = XStart;
          end
          default: ;
        endcase
      end
      n_hit = n_hit + 4'(hit[i]);
      n_imp = n_imp + 4'(impact[i]);
    end

    kill_sum    = {1'b0, killcount_q} + (OUT_WIDTH + 1)'(n_hit);
    killcount_d = (kill_sum > {1'b0, KillMax}) ? KillMax : kill_sum[OUT_WIDTH-1:0];
    lives_d     = (lives_q > n_imp) ? lives_q - n_imp : '0;
    game_over_d = game_over_q | (lives_d == '0);

    // Losing the last life parks every channel on the same edge.
    if (game_over_d && !game_over_q) begin
      for (int unsigned i = 0; i < N_ENEMY; i++) begin
        state_d[i] = StIdle;
        cnt_d[i]   = '0;
        x_d[i]     = XStart;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_ENEMY; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
        x_q[i]     <= XStart;
      end
      spawn_q     <= '0;
      adr_q       <= {N_ENEMY{ADR_BOMBER}};
      nuked_q     <= '0;
      killcount_q <= '0;
      lives_q     <= 4'(LIVES);
      game_over_q <= 1'b0;
      click_q     <= 1'b0;
      fire_q      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_ENEMY; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        x_q[i]     <= x_d[i];
        spawn_q[i] <= (state_d[i] == StFly) || (state_d[i] == StExplode);
        adr_q[i*ADDRESSWIDTH +: ADDRESSWIDTH] <=
            (state_d[i] == StExplode) ? ADR_EXPLODE : ADR_BOMBER;
      end
      nuked_q     <= nuked_d;
      killcount_q <= killcount_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
      click_q     <= click;
      fire_q      <= click & ~click_q;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_ENEMY; i++) begin
      xenemy[i*OUT_WIDTH +: OUT_WIDTH] = x_q[i];
      yenemy[i*OUT_WIDTH +: OUT_WIDTH] = chan_y(i);
    end
  end

  assign spawn_enemy = spawn_q;
  assign adr_enemy   = adr_q;
  assign base_nuked  = nuked_q;
  assign killcount   = killcount_q;
  assign lives       = lives_q;
  assign game_over   = game_over_q;

endmodule
